testpattern_gen: RTL and testbench
==================================

# testpattern_gen

Parametrised multi-mode test-pattern generator for the N64 video pipeline. It sits in the PPU in place of the incoming pixel stream. It derives horizontal and vertical position from the incoming sync word and paints one of four frame-synchronously selectable patterns into the active window. Sync passes through, delayed by one valid cycle; the output is registered.

## Interface
Parameters:
- COLOR_WIDTH, 7, bits per colour channel
- HCNT_WIDTH, 10, horizontal counter width
- VCNT_WIDTH, 9, vertical counter width
- HSTART_NTSC / HSTOP_NTSC, 62 / 702, NTSC active window, in hcnt units
- HSTART_PAL / HSTOP_PAL, 66 / 706, PAL active window, in hcnt units
- VSTART_NTSC / VSTOP_NTSC, 18 / 258, NTSC active lines, in vcnt units
- VSTART_PAL / VSTOP_PAL, 23 / 311, PAL active lines, in vcnt units
- BAR_WIDTH, 80, pixels per colour bar
- RAMP_STEP, 5, pixels per grey-ramp increment

Ports:
- VCLK  in  1  video clock
- nRST  in  1  asynchronous, active-low reset
- palmode  in  1  1 = PAL window limits, 0 = NTSC
- pattern_sel  in  2  0 checkerboard, 1 colour bars, 2 grey ramp, 3 border frame
- vdata_sync_valid_i  in  1  pixel-valid strobe
- vdata_sync_i  in  4  {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
- vdata_valid_o  out  1  registered copy of vdata_sync_valid_i
- vdata_o  out  3*COLOR_WIDTH+4  {sync[3:0], R, G, B}

## Operation
- Edge detection compares the registered output sync bits with the input, on valid cycles only:
  - nHSYNC negedge: vdata_o[3*COLOR_WIDTH+1]=1 and vdata_sync_i[1]=0.
  - nVSYNC negedge: same test on bit 3 of each.
- hcnt:
  - Clears on an nHSYNC negedge.
  - Otherwise increments, saturating at all-ones.
- vcnt:
  - Increments on an nHSYNC negedge, saturating at all-ones.
  - Clears on an nVSYNC negedge. VSYNC wins if both edges occur in the same cycle; hcnt still clears.
- Active pixel:
  - Start pixel: hcnt == hstart.
  - Interior pixels: hstart < hcnt < hstop.
  - Active line: vstart <= vcnt < vstop.
  - hstart, hstop, vstart and vstop are muxed by palmode.
  - Colour outside the window is 0.
- pattern_sel is captured into an internal active_pat register only on an nVSYNC negedge. Changes mid-frame take effect at the next frame.
- Pattern 0, checkerboard:
  - Start pixel: all colour bits = vcnt[0].
  - Interior pixels: all colour bits = ~vdata_o[0].
- Pattern 1, colour bars:
  - bar_idx and bar_cnt reset to 0 at the start pixel.
  - bar_cnt counts to BAR_WIDTH-1, then wraps and increments bar_idx. bar_idx saturates at 7.
  - Colours by index 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or all-zeros.
- Pattern 2, grey ramp:
  - ramp_val and ramp_cnt reset to 0 at the start pixel.
  - ramp_val increments every RAMP_STEP pixels, saturating at all-ones of COLOR_WIDTH.
  - R = G = B = ramp_val.
- Pattern 3, border frame:
  - White (all-ones) on a window-edge pixel: hcnt==hstart, hcnt==hstop-1, vcnt==vstart or vcnt==vstop-1.
  - Black elsewhere.
- Sync: vdata_o sync slice <= vdata_sync_i on each valid cycle.
- Invalid cycles: no counter, pattern state or vdata_o update. vdata_valid_o still follows the input.

## Timing
- Latency: 1 VCLK from input to vdata_o and vdata_valid_o.
- Reset values, asynchronous and immediate on nRST low, released on the next VCLK edge:
  - vdata_o = 0.
  - vdata_valid_o = 0.
  - hcnt, vcnt, bar/ramp counters = 0.
  - active_pat = 0.
- Reset mid-frame: counters restart at 0. No pattern is shown until vcnt reaches vstart after the next nHSYNC edges.
- palmode is sampled combinationally each cycle; no frame synchronisation.

## Configuration
- TESTPATTERN_COLORBARS_EN defined: pattern 1 produces colour bars as above.
- TESTPATTERN_COLORBARS_EN undefined:
  - Pattern 1 behaves exactly as pattern 0 (checkerboard).
  - bar_idx and bar_cnt logic is not synthesised.

## Test plan
- Checkerboard, NTSC, pattern_sel=0, valid every cycle, vcnt=18 (even) → at hcnt=62 colour = 0; at hcnt 63, 64, 65 colour = all-ones, 0, all-ones. On line 19 the phase is inverted.
- Colour bars, pattern_sel=1 with macro defined, NTSC → hcnt 62..141 white; 142..221 R,G all-ones with B=0 (yellow); bar index stays 7 (black) until hstop. With the macro undefined, output equals pattern 0.
- Frame-synchronous switch → change pattern_sel 0→2 mid-frame: checkerboard continues. After the nVSYNC negedge the next active line shows a ramp with value 0 at pixels 62..66 and 1 at 67..71.
- Boundaries → simultaneous nHSYNC and nVSYNC negedge gives vcnt=0 and hcnt=0. With no HSYNC, hcnt saturates at 1023 and does not wrap.
- Valid gating and reset → vdata_sync_valid_i=0 for 3 cycles freezes vdata_o and counters while vdata_valid_o=0. nRST pulse mid-line gives vdata_o=0 immediately and colour 0 until the window is re-entered.
- PAL window → palmode=1, pattern_sel=3: white at vcnt=23, vcnt=310, hcnt=66 and hcnt=705. Black at vcnt=311 and hcnt=706.

Source files
------------

// File: rtl/testpattern_gen.sv
// Test-pattern source for the video pipeline: paints one of four patterns into the active window and forwards sync; 1 VCLK latency.
// No backpressure: vdata_sync_valid_i low freezes all state and vdata_o, vdata_valid_o follows the strobe.
// Optional TESTPATTERN_COLORBARS_EN enables colour bars on pattern 1 (otherwise pattern 1 repeats the checkerboard).
module testpattern_gen #(
   parameter int COLOR_WIDTH = 7,
   parameter int HCNT_WIDTH  = 10,
   parameter int VCNT_WIDTH  = 9,
   parameter int HSTART_NTSC = 62,
   parameter int HSTOP_NTSC  = 702,
   parameter int HSTART_PAL  = 66,
   parameter int HSTOP_PAL   = 706,
   parameter int VSTART_NTSC = 18,
   parameter int VSTOP_NTSC  = 258,
   parameter int VSTART_PAL  = 23,
   parameter int VSTOP_PAL   = 311,
   parameter int BAR_WIDTH   = 80,
   parameter int RAMP_STEP   = 5
) (
   input  logic                       VCLK,
   input  logic                       nRST,
   input  logic                       palmode,
   input  logic [1:0]                 pattern_sel,
   input  logic                       vdata_sync_valid_i,
   input  logic [3:0]                 vdata_sync_i,
   output logic                       vdata_valid_o,
   output logic [3*COLOR_WIDTH+3:0]   vdata_o
);

   localparam int CW  = 3 * COLOR_WIDTH;
   localparam int RCW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

   if (BAR_WIDTH < 1 || RAMP_STEP < 1) begin : g_cfg_check
      $error("testpattern_gen: BAR_WIDTH and RAMP_STEP must be positive");
   end

   logic [HCNT_WIDTH-1:0]  hcnt_q, hcnt_d, hstart, hstop;
   logic [VCNT_WIDTH-1:0]  vcnt_q, vcnt_d, vstart, vstop;
   logic [1:0]             active_pat_q, active_pat_d;
   logic [COLOR_WIDTH-1:0] ramp_val_q, ramp_val_d;
   logic [RCW-1:0]         ramp_cnt_q, ramp_cnt_d;
   logic [CW-1:0]          color;
   logic                   hs_edge, vs_edge, line_act, px_start, px_act, border, chk_bit;

   assign hstart = palmode ? HCNT_WIDTH'(HSTART_PAL) : HCNT_WIDTH'(HSTART_NTSC);
   assign hstop  = palmode ? HCNT_WIDTH'(HSTOP_PAL)  : HCNT_WIDTH'(HSTOP_NTSC);
   assign vstart = palmode ? VCNT_WIDTH'(VSTART_PAL) : VCNT_WIDTH'(VSTART_NTSC);
   assign vstop  = palmode ? VCNT_WIDTH'(VSTOP_PAL)  : VCNT_WIDTH'(VSTOP_NTSC);

   // The registered sync slice holds the previous valid cycle's sync word.
   assign hs_edge = vdata_o[CW+1] & ~vdata_sync_i[1];
   assign vs_edge = vdata_o[CW+3] & ~vdata_sync_i[3];

   assign line_act = (vcnt_q >= vstart) && (vcnt_q < vstop);
   assign px_start = line_act && (hcnt_q == hstart);
   assign px_act   = px_start || (line_act && (hcnt_q > hstart) && (hcnt_q < hstop));
   assign border   = (hcnt_q == hstart) || (hcnt_q == hstop - 1'b1) ||
                     (vcnt_q == vstart) || (vcnt_q == vstop - 1'b1);
   assign chk_bit  = px_start ? vcnt_q[0] : ~vdata_o[0];

   always_comb begin
      hcnt_d       = hcnt_q;
      vcnt_d       = vcnt_q;
      active_pat_d = active_pat_q;
      if (hs_edge)
         hcnt_d = '0;
      else if (hcnt_q != '1)
         hcnt_d = hcnt_q + 1'b1;
      if (vs_edge) begin
         vcnt_d       = '0;
         active_pat_d = pattern_sel;
      end else if (hs_edge && (vcnt_q != '1)) begin
         vcnt_d = vcnt_q + 1'b1;
      end
   end

   // Ramp registers hold the value shown on the current pixel.
   always_comb begin
      ramp_val_d = ramp_val_q;
      ramp_cnt_d = ramp_cnt_q;
      if (px_start) begin
         ramp_val_d = '0;
         ramp_cnt_d = '0;
      end else if (px_act) begin
         if (ramp_cnt_q == RCW'(RAMP_STEP - 1)) begin
            ramp_cnt_d = '0;
            if (ramp_val_q != '1)
               ramp_val_d = ramp_val_q + 1'b1;
         end else begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
         end
      end
   end

`ifdef TESTPATTERN_COLORBARS_EN
   localparam int BCW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

   logic [2:0]     bar_idx_q, bar_idx_d;
   logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]     bar_rgb;

   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_cnt_d = bar_cnt_q;
      if (px_start) begin
         bar_idx_d = '0;
         bar_cnt_d = '0;
      end else if (px_act) begin
         if (bar_cnt_q == BCW'(BAR_WIDTH - 1)) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 3'd7)
               bar_idx_d = bar_idx_q + 3'd1;
         end else begin
            bar_cnt_d = bar_cnt_q + 1'b1;
         end
      end
   end

   // White, yellow, cyan, green, magenta, red, blue, black reduces to inverted index bits.
   assign bar_rgb = {~bar_idx_d[1], ~bar_idx_d[2], ~bar_idx_d[0]};

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         bar_idx_q <= '0;
         bar_cnt_q <= '0;
      end else if (vdata_sync_valid_i) begin
         bar_idx_q <= bar_idx_d;
         bar_cnt_q <= bar_cnt_d;
      end
   end
`endif

   always_comb begin
      color = '0;
      case (active_pat_q)
`ifdef TESTPATTERN_COLORBARS_EN
         2'd1:    color = {{COLOR_WIDTH{bar_rgb[2]}}, {COLOR_WIDTH{bar_rgb[1]}}, {COLOR_WIDTH{bar_rgb[0]}}};
`else
         2'd1:    color = {CW{chk_bit}};
`endif
         2'd2:    color = {3{ramp_val_d}};
         2'd3:    color = border ? '1 : '0;
         default: color = {CW{chk_bit}};
      endcase
      if (!px_act)
         color = '0;
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         vdata_valid_o <= 1'b0;
         vdata_o       <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         active_pat_q  <= '0;
         ramp_val_q    <= '0;
         ramp_cnt_q    <= '0;
      end else begin
         vdata_valid_o <= vdata_sync_valid_i;
         if (vdata_sync_valid_i) begin
            vdata_o      <= {vdata_sync_i, color};
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            active_pat_q <= active_pat_d;
            ramp_val_q   <= ramp_val_d;
            ramp_cnt_q   <= ramp_cnt_d;
         end
      end
   end

endmodule

// File: tb/tb_testpattern_gen.sv
// Bench for testpattern_gen: directed frame sequences plus randomised frames against an arithmetic pixel model.
module tb_testpattern_gen;

   localparam logic [20:0] ALL1 = '1;

   logic        VCLK = 1'b0;
   logic        nRST;
   logic        palmode;
   logic [1:0]  pattern_sel;
   logic        vdata_sync_valid_i;
   logic [3:0]  vdata_sync_i;
   logic        vdata_valid_o;
   logic [24:0] vdata_o;

   int checks = 0;
   int failures = 0;

   int          m_h, m_v, m_pat;
   logic [3:0]  m_sync;
   logic [24:0] exp_vdata;
   logic        exp_valid;
   logic [20:0] cap [0:1023];
   logic [24:0] saved_vdata;
   logic [31:0] saved_hcnt;

   testpattern_gen dut (
      .VCLK               (VCLK),
      .nRST               (nRST),
      .palmode            (palmode),
      .pattern_sel        (pattern_sel),
      .vdata_sync_valid_i (vdata_sync_valid_i),
      .vdata_sync_i       (vdata_sync_i),
      .vdata_valid_o      (vdata_valid_o),
      .vdata_o            (vdata_o)
   );

   always #5 VCLK = ~VCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Colour of a pixel at position (h, v), straight from the pattern definitions.
   function automatic logic [20:0] ref_color(input int h, input int v, input int pat, input logic pal);
      int hs, he, vs, ve, idx, r;
      logic [2:0] rgb;
      logic b;
      hs = pal ? 66 : 62;
      he = pal ? 706 : 702;
      vs = pal ? 23 : 18;
      ve = pal ? 311 : 258;
      if (v < vs || v >= ve || h < hs || h >= he) return '0;
`ifndef TESTPATTERN_COLORBARS_EN
      if (pat == 1) pat = 0;
`endif
      case (pat)
         1: begin
            idx = (h - hs) / 80;
            if (idx > 7) idx = 7;
            case (idx)
               0: rgb = 3'b111;
               1: rgb = 3'b110;
               2: rgb = 3'b011;
               3: rgb = 3'b010;
               4: rgb = 3'b101;
               5: rgb = 3'b100;
               6: rgb = 3'b001;
               default: rgb = 3'b000;
            endcase
            return {{7{rgb[2]}}, {7{rgb[1]}}, {7{rgb[0]}}};
         end
         2: begin
            r = (h - hs) / 5;
            if (r > 127) r = 127;
            return {3{7'(r)}};
         end
         3: return (h == hs || h == he - 1 || v == vs || v == ve - 1) ? ALL1 : '0;
         default: begin
            b = ((v + h - hs) % 2) != 0;
            return {21{b}};
         end
      endcase
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_pat = 0; m_sync = '0;
      exp_vdata = '0; exp_valid = 1'b0;
   endtask

   task automatic cyc(input logic v, input logic [3:0] s);
      int h0;
      logic hs_e, vs_e;
      h0 = 0;
      vdata_sync_valid_i = v;
      vdata_sync_i = s;
      @(posedge VCLK);
      exp_valid = v;
      if (v) begin
         h0 = m_h;
         exp_vdata = {s, ref_color(m_h, m_v, m_pat, palmode)};
         hs_e = m_sync[1] && !s[1];
         vs_e = m_sync[3] && !s[3];
         if (hs_e) m_h = 0;
         else if (m_h < 1023) m_h++;
         if (vs_e) begin
            m_v = 0;
            m_pat = int'(pattern_sel);
         end else if (hs_e && m_v < 511) begin
            m_v++;
         end
         m_sync = s;
      end
      #1;
      chk("vdata", 32'(vdata_o), 32'(exp_vdata));
      chk("valid", 32'(vdata_valid_o), 32'(exp_valid));
      if (v) cap[h0] = vdata_o[20:0];
   endtask

   // vs_mode: 0 no vsync, 1 vsync edge together with hsync edge, 2 vsync edge mid-line.
   task automatic line(input int len, input int vs_mode, input int gap_pct, input bit with_hs);
      logic nh, nv;
      for (int i = 0; i < len; i++) begin
         nh = !with_hs || (i >= 4);
         nv = 1'b1;
         if (vs_mode == 1 && i < 4) nv = 1'b0;
         if (vs_mode == 2 && i >= 10 && i < 14) nv = 1'b0;
         while (int'($urandom_range(99)) < gap_pct) cyc(1'b0, 4'($urandom));
         cyc(1'b1, {nv, 1'b1, nh, nh & nv});
      end
   endtask

   task automatic short_until(input int vtarget);
      while (m_v < vtarget - 1) line(int'($urandom_range(30, 70)), 0, 20, 1'b1);
   endtask

   task automatic full_line();
      for (int i = 0; i < 1024; i++) cap[i] = 'x;
      line(720, 0, 15, 1'b1);
   endtask

   initial begin
      nRST = 1'b0; palmode = 1'b0; pattern_sel = 2'd0;
      vdata_sync_valid_i = 1'b0; vdata_sync_i = '0;
      model_reset();
      repeat (2) @(posedge VCLK);
      #1;
      chk("rst_vdata", 32'(vdata_o), 32'h0);
      chk("rst_valid", 32'(vdata_valid_o), 32'h0);
      @(negedge VCLK);
      nRST = 1'b1;

      // Simultaneous hsync/vsync edge after a few lines.
      repeat (3) line(10, 0, 0, 1'b1);
      line(20, 1, 0, 1'b1);
      chk("sim_edge_vcnt", 32'(dut.vcnt_q), 32'd0);
      chk("sim_edge_hcnt", 32'(dut.hcnt_q), 32'd19);

      // Checkerboard, NTSC.
      short_until(18);
      full_line();
      chk("cb18_62", 32'(cap[62]), 32'h0);
      chk("cb18_63", 32'(cap[63]), 32'(ALL1));
      chk("cb18_64", 32'(cap[64]), 32'h0);
      chk("cb18_65", 32'(cap[65]), 32'(ALL1));
      full_line();
      chk("cb19_62", 32'(cap[62]), 32'(ALL1));
      chk("cb19_63", 32'(cap[63]), 32'h0);

      // Valid gating mid-line.
      line(300, 0, 0, 1'b1);
      saved_vdata = vdata_o;
      saved_hcnt = 32'(dut.hcnt_q);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'($urandom));
         chk("gate_vdata", 32'(vdata_o), 32'(saved_vdata));
         chk("gate_valid", 32'(vdata_valid_o), 32'h0);
         chk("gate_hcnt", 32'(dut.hcnt_q), saved_hcnt);
      end
      line(420, 0, 0, 1'b0);

      // Mid-frame pattern change waits for the next frame.
      pattern_sel = 2'd2;
      full_line();
      chk("sw_keep62", 32'(cap[62]), 32'(ALL1));
      chk("sw_keep63", 32'(cap[63]), 32'h0);
      line(20, 1, 20, 1'b1);
      short_until(18);
      full_line();
      chk("ramp62", 32'(cap[62]), 32'h0);
      chk("ramp66", 32'(cap[66]), 32'h0);
      chk("ramp67", 32'(cap[67]), 32'({3{7'd1}}));
      chk("ramp71", 32'(cap[71]), 32'({3{7'd1}}));
      chk("ramp72", 32'(cap[72]), 32'({3{7'd2}}));

      // Pattern 1.
      pattern_sel = 2'd1;
      line(20, 1, 20, 1'b1);
      short_until(18);
      full_line();
`ifdef TESTPATTERN_COLORBARS_EN
      chk("bars62", 32'(cap[62]), 32'(ALL1));
      chk("bars141", 32'(cap[141]), 32'(ALL1));
      chk("bars142", 32'(cap[142]), 32'({7'h7f, 7'h7f, 7'h00}));
      chk("bars542", 32'(cap[542]), 32'({7'h00, 7'h00, 7'h7f}));
      chk("bars701", 32'(cap[701]), 32'h0);
`else
      chk("bars62", 32'(cap[62]), 32'h0);
      chk("bars63", 32'(cap[63]), 32'(ALL1));
      chk("bars64", 32'(cap[64]), 32'h0);
`endif

      // Asynchronous reset mid-line.
      line(200, 0, 0, 1'b1);
      #2 nRST = 1'b0;
      #1;
      chk("rstmid_vdata", 32'(vdata_o), 32'h0);
      chk("rstmid_valid", 32'(vdata_valid_o), 32'h0);
      model_reset();
      @(negedge VCLK);
      nRST = 1'b1;
      line(500, 0, 10, 1'b0);
      chk("rstmid_vcnt", 32'(dut.vcnt_q), 32'h0);

      // hcnt saturation without hsync.
      line(1100, 0, 0, 1'b1);
      chk("sat_hcnt", 32'(dut.hcnt_q), 32'd1023);

      // PAL border frame.
      palmode = 1'b1;
      pattern_sel = 2'd3;
      line(20, 2, 20, 1'b1);
      short_until(23);
      full_line();
      chk("pal_v23_300", 32'(cap[300]), 32'(ALL1));
      short_until(100);
      full_line();
      chk("pal_h65", 32'(cap[65]), 32'h0);
      chk("pal_h66", 32'(cap[66]), 32'(ALL1));
      chk("pal_h300", 32'(cap[300]), 32'h0);
      chk("pal_h705", 32'(cap[705]), 32'(ALL1));
      chk("pal_h706", 32'(cap[706]), 32'h0);
      short_until(310);
      full_line();
      chk("pal_v310_300", 32'(cap[300]), 32'(ALL1));
      full_line();
      chk("pal_v311_300", 32'(cap[300]), 32'h0);
      chk("pal_v311_66", 32'(cap[66]), 32'h0);

      // Randomised frames checked cycle by cycle against the model.
      for (int f = 0; f < 2; f++) begin
         palmode = 1'($urandom);
         pattern_sel = 2'($urandom);
         line(20, int'($urandom_range(1, 2)), 25, 1'b1);
         for (int l = 0; l < 80; l++) begin
            if ($urandom_range(9) == 0) pattern_sel = 2'($urandom);
            if ($urandom_range(4) == 0) line(720, 0, 25, 1'b1);
            else line(int'($urandom_range(30, 90)), 0, 25, 1'b1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
